// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus constants, sequencer state encoding and registered bus-output bundle
// for the mode-2 interrupt-acknowledge / RETI initiator.
package z80_bus_pkg;

    localparam logic [7:0] OPC_ED = 8'hED;
    localparam logic [7:0] OPC_4D = 8'h4D;
    localparam logic [7:0] OPC_CB = 8'hCB;

    localparam int unsigned TW_DEFAULT        = 2;
    localparam int unsigned FETCH_LEN_DEFAULT = 2;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ACK_T1   = 3'd1;
    localparam logic [2:0] ST_ACK_IO   = 3'd2;
    localparam logic [2:0] ST_ACK_END  = 3'd3;
    localparam logic [2:0] ST_RF_LO    = 3'd4;
    localparam logic [2:0] ST_RF_HI    = 3'd5;
    localparam logic [2:0] ST_RETI_END = 3'd6;

    typedef struct packed {
        logic       m1_n;
        logic       iorq_n;
        logic       rd_n;
        logic       do_en;
        logic [7:0] dout;
        logic       vec_valid;
        logic       reti_done;
        logic       busy;
    } bus_out_t;

    localparam bus_out_t BUS_OUT_RESET = '{
        m1_n:      1'b1,
        iorq_n:    1'b1,
        rd_n:      1'b1,
        do_en:     1'b0,
        dout:      8'h00,
        vec_valid: 1'b0,
        reti_done: 1'b0,
        busy:      1'b0
    };

    // Mode-2 table entries are word aligned, so the vector's LSB is forced to 0.
    function automatic logic [15:0] mode2_addr(input logic [7:0] page, input logic [7:0] vec);
        return {page, vec & 8'hFE};
    endfunction

endpackage

// File: rtl/z80_sync2.sv
// Two-flop synchroniser for the asynchronous daisy-chain INT_n line; resets to the
// inactive (high) level so a reset never looks like a pending interrupt.
module z80_sync2 (
    input  logic CLK,
    input  logic RESET,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/z80_int_ack_seq.sv
// Z80 mode-2 interrupt-acknowledge initiator: runs the M1+IORQ vector cycle, forms the
// table address and emits the ED/4D RETI fetch pair that releases the daisy chain.
module z80_int_ack_seq
    import z80_bus_pkg::*;
#(
    parameter int unsigned TW        = TW_DEFAULT,
    parameter int unsigned FETCH_LEN = FETCH_LEN_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        INT_n,
    input  logic        IE,
    input  logic [7:0]  I_REG,
    input  logic [7:0]  DI,
    input  logic        RETI_REQ,
    output logic        M1_n,
    output logic        IORQ_n,
    output logic        RD_n,
    output logic [7:0]  DO,
    output logic        DO_EN,
    output logic        IEI_TOP,
    output logic [15:0] VEC_ADDR,
    output logic        VEC_VALID,
    output logic        RETI_DONE,
    output logic        BUSY
);

    // Dwell counter reload values: each state leaves when the counter reaches zero.
    localparam logic [2:0] T1_LOAD = 3'd1;
    localparam logic [2:0] IO_LOAD = 3'(TW);
    localparam logic [2:0] RF_LOAD = 3'(FETCH_LEN - 1);

    logic        int_s;
    logic        ack_req;

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [7:0]  opc_q,   opc_d;
    logic [15:0] vec_q,   vec_d;
    logic        pend_q,  pend_d;
    bus_out_t    out_q,   out_d;

    z80_sync2 u_int_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d_i   (INT_n),
        .q_o   (int_s)
    );

    assign ack_req = !int_s && IE;

    // NOTE: every variable gets a default at the top of always_comb; a path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opc_d   = opc_q;
        vec_d   = vec_q;

        case (state_q)
            ST_IDLE: begin
                // A RETI request seen in IDLE holds off the acknowledge for one cycle
                // so the pending RETI always wins over a simultaneous interrupt.
                if (pend_q) begin
                    state_d = ST_RF_LO;
                    cnt_d   = RF_LOAD;
                    opc_d   = OPC_ED;
                end else if (!RETI_REQ && ack_req) begin
                    state_d = ST_ACK_T1;
                    cnt_d   = T1_LOAD;
                end
            end
            ST_ACK_T1: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_ACK_IO;
                    cnt_d   = IO_LOAD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK_IO: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_ACK_END;
                    vec_d   = mode2_addr(I_REG, DI);
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK_END: begin
                state_d = ST_IDLE;
            end
            ST_RF_LO: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_RF_HI;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RF_HI: begin
                if (opc_q == OPC_ED) begin
                    state_d = ST_RF_LO;
                    cnt_d   = RF_LOAD;
                    opc_d   = OPC_4D;
                end else begin
                    state_d = ST_RETI_END;
                end
            end
            ST_RETI_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One-deep pending RETI: consumed when IDLE starts the ED fetch, further requests dropped.
    always_comb begin
        pend_d = pend_q;
        if (state_q == ST_IDLE && pend_q) begin
            pend_d = 1'b0;
        end else if (RETI_REQ) begin
            pend_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so every strobe comes straight off a flop.
    always_comb begin
        out_d = BUS_OUT_RESET;
        case (state_d)
            ST_ACK_T1: begin
                out_d.m1_n = 1'b0;
            end
            ST_ACK_IO: begin
                out_d.m1_n   = 1'b0;
                out_d.iorq_n = 1'b0;
            end
            ST_ACK_END: begin
                out_d.vec_valid = 1'b1;
            end
            ST_RF_LO: begin
                out_d.m1_n  = 1'b0;
                out_d.rd_n  = 1'b0;
                out_d.do_en = 1'b1;
                out_d.dout  = opc_d;
            end
            ST_RF_HI: begin
                out_d.do_en = 1'b1;
                out_d.dout  = opc_d;
            end
            ST_RETI_END: begin
                out_d.reti_done = 1'b1;
            end
            default: begin
                out_d = BUS_OUT_RESET;
            end
        endcase
        out_d.busy = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled at the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            opc_q   <= OPC_ED;
            vec_q   <= 16'h0000;
            pend_q  <= 1'b0;
            out_q   <= BUS_OUT_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
            vec_q   <= vec_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
        end
    end

    assign M1_n      = out_q.m1_n;
    assign IORQ_n    = out_q.iorq_n;
    assign RD_n      = out_q.rd_n;
    assign DO        = out_q.dout;
    assign DO_EN     = out_q.do_en;
    assign VEC_VALID = out_q.vec_valid;
    assign RETI_DONE = out_q.reti_done;
    assign BUSY      = out_q.busy;
    assign VEC_ADDR  = vec_q;
    assign IEI_TOP   = 1'b1;

endmodule

// File: tb/tb_z80_int_ack_seq.sv
// Self-checking bench: scenario windows driven with $urandom parameters, compared against a
// transaction-level timeline model and a daisy-chain peripheral that watches ack and RETI.
module tb_z80_int_ack_seq;

    localparam int TW = 2;
    localparam int FL = 2;
    localparam int W  = 40;

    logic        CLK = 1'b0;
    logic        RESET, INT_n, IE, RETI_REQ;
    logic [7:0]  I_REG, DI;
    logic        M1_n, IORQ_n, RD_n, DO_EN, IEI_TOP, VEC_VALID, RETI_DONE, BUSY;
    logic [7:0]  DO;
    logic [15:0] VEC_ADDR;

    always #5 CLK = ~CLK;

    z80_int_ack_seq #(.TW(TW), .FETCH_LEN(FL)) dut (
        .CLK(CLK), .RESET(RESET), .INT_n(INT_n), .IE(IE), .I_REG(I_REG), .DI(DI),
        .RETI_REQ(RETI_REQ), .M1_n(M1_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .DO(DO),
        .DO_EN(DO_EN), .IEI_TOP(IEI_TOP), .VEC_ADDR(VEC_ADDR), .VEC_VALID(VEC_VALID),
        .RETI_DONE(RETI_DONE), .BUSY(BUSY)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scenario description; an *_at value of 0 means "never".
    int         sc_int_at, sc_ie_at, sc_ie_off, sc_reti_at, sc_reti2_at, sc_rst_at;
    bit         sc_pre_low;
    logic [7:0] sc_page, sc_vec;

    // Observed (active level = 1) and expected per-sample vectors, bit i = sample after edge i.
    logic [63:0] s_m1, s_iorq, s_rd, s_doen, s_vv, s_rdone, s_busy;
    logic [63:0] e_m1, e_iorq, e_rd, e_doen, e_vv, e_rdone, e_busy;
    logic [7:0]  s_do [1:W];
    logic [7:0]  e_do [1:W];
    logic [15:0] model_va = 16'h0000;
    bit          model_srv = 1'b0;

    // Daisy-chain peripheral: drops INT_n and enters service on the vector read,
    // leaves service when it latches ED then 4D on RD_n rising.
    bit   periph_srv = 1'b0;
    bit   saw_ed     = 1'b0;
    logic prev_rd    = 1'b1;

    task automatic tick();
        @(posedge CLK);
        #1;
        if (!IORQ_n && !M1_n) begin
            INT_n      = 1'b1;
            periph_srv = 1'b1;
        end
        if (!prev_rd && RD_n) begin
            if (DO == 8'hED) begin
                saw_ed = 1'b1;
            end else begin
                if (DO == 8'h4D && saw_ed) periph_srv = 1'b0;
                saw_ed = 1'b0;
            end
        end
        prev_rd = RD_n;
    endtask

    function automatic logic [63:0] span(input int from, input int len);
        logic [63:0] m = '0;
        for (int k = 0; k < len; k++)
            if (from + k >= 1 && from + k <= W) m[from + k] = 1'b1;
        return m;
    endfunction

    task automatic clear_sc();
        sc_int_at = 0; sc_ie_at = 1; sc_ie_off = 0; sc_reti_at = 0; sc_reti2_at = 0;
        sc_rst_at = 0; sc_pre_low = 1'b0;
        sc_page = 8'($urandom_range(0, 255));
        sc_vec  = 8'($urandom_range(0, 255));
    endtask

    // Timeline model: at each decision edge the idle sequencer serves a registered RETI,
    // skips the edge a RETI request arrives on, or starts the acknowledge.
    task automatic run_model();
        int  e   = 1;
        int  lim = (sc_rst_at != 0) ? sc_rst_at : W + 1;
        bit  acked  = 1'b0;
        bit  served = (sc_reti_at == 0);
        bit  int_ok, ie_ok;
        e_m1 = '0; e_iorq = '0; e_rd = '0; e_doen = '0; e_vv = '0; e_rdone = '0; e_busy = '0;
        for (int i = 1; i <= W; i++) e_do[i] = 8'h00;
        while (e <= W && e < lim) begin
            int_ok = sc_pre_low || (sc_int_at != 0 && e >= sc_int_at + 2);
            ie_ok  = (e >= sc_ie_at) && (sc_ie_off == 0 || e < sc_ie_off);
            if (!served && sc_reti_at < e) begin
                e_m1    |= span(e, FL) | span(e + FL + 1, FL);
                e_rd    |= span(e, FL) | span(e + FL + 1, FL);
                e_doen  |= span(e, 2 * FL + 2);
                e_rdone |= span(e + 2 * FL + 2, 1);
                e_busy  |= span(e, 2 * FL + 3);
                for (int k = 0; k <= 2 * FL + 1; k++)
                    if (e + k <= W) e_do[e + k] = (k <= FL) ? 8'hED : 8'h4D;
                if (e + 2 * FL + 1 < lim) model_srv = 1'b0;
                served = 1'b1;
                e += 2 * FL + 4;
            end else if (!served && sc_reti_at == e) begin
                e++;
            end else if (!acked && int_ok && ie_ok) begin
                e_m1   |= span(e, TW + 3);
                e_iorq |= span(e + 2, TW + 1);
                e_vv   |= span(e + TW + 3, 1);
                e_busy |= span(e, TW + 4);
                if (e + TW + 3 < lim) model_va = {sc_page, sc_vec[7:1], 1'b0};
                if (e + 2 < lim) model_srv = 1'b1;
                acked = 1'b1;
                e += TW + 5;
            end else begin
                e++;
            end
        end
        if (sc_rst_at != 0) begin
            e_m1 &= span(1, sc_rst_at - 1);   e_iorq  &= span(1, sc_rst_at - 1);
            e_rd &= span(1, sc_rst_at - 1);   e_doen  &= span(1, sc_rst_at - 1);
            e_vv &= span(1, sc_rst_at - 1);   e_rdone &= span(1, sc_rst_at - 1);
            e_busy &= span(1, sc_rst_at - 1);
            model_va = 16'h0000;
        end
    endtask

    task automatic run_scenario(input string name);
        int pre_act = 0;
        int ovl     = 0;
        RETI_REQ = 1'b0; RESET = 1'b0; IE = 1'b0;
        INT_n = sc_pre_low ? 1'b0 : 1'b1;
        repeat (sc_pre_low ? 20 : 3) begin
            tick();
            if (!M1_n || !IORQ_n || !RD_n || BUSY) pre_act++;
        end
        check($sformatf("%s.pre_idle", name), pre_act, 0);
        I_REG = sc_page; DI = sc_vec;
        s_m1 = '0; s_iorq = '0; s_rd = '0; s_doen = '0; s_vv = '0; s_rdone = '0; s_busy = '0;
        for (int i = 1; i <= W; i++) begin
            RETI_REQ = (i == sc_reti_at) || (i == sc_reti2_at);
            RESET    = (i == sc_rst_at);
            IE       = (i >= sc_ie_at) && (sc_ie_off == 0 || i < sc_ie_off);
            if (i == sc_int_at) INT_n = 1'b0;
            tick();
            s_m1[i] = ~M1_n;  s_iorq[i] = ~IORQ_n; s_rd[i] = ~RD_n; s_doen[i] = DO_EN;
            s_vv[i] = VEC_VALID; s_rdone[i] = RETI_DONE; s_busy[i] = BUSY; s_do[i] = DO;
            if (!IORQ_n && !RD_n) ovl++;
        end
        RETI_REQ = 1'b0; RESET = 1'b0; IE = 1'b0; INT_n = 1'b1;
        run_model();
        check($sformatf("%s.m1_low", name),    s_m1,    e_m1);
        check($sformatf("%s.iorq_low", name),  s_iorq,  e_iorq);
        check($sformatf("%s.rd_low", name),    s_rd,    e_rd);
        check($sformatf("%s.do_en", name),     s_doen,  e_doen);
        check($sformatf("%s.vec_valid", name), s_vv,    e_vv);
        check($sformatf("%s.reti_done", name), s_rdone, e_rdone);
        check($sformatf("%s.busy", name),      s_busy,  e_busy);
        check($sformatf("%s.vec_addr", name),  VEC_ADDR, model_va);
        check($sformatf("%s.iorq_rd_ovl", name), ovl, 0);
        check($sformatf("%s.ieo", name), !periph_srv, !model_srv);
        for (int i = 1; i <= W; i++)
            if (e_doen[i]) check($sformatf("%s.do[%0d]", name, i), s_do[i], e_do[i]);
    endtask

    initial begin
        int kind;
        RESET = 1'b1; INT_n = 1'b1; IE = 1'b0; RETI_REQ = 1'b0; I_REG = 8'h00; DI = 8'hFF;

        repeat (3) tick();
        check("rst.m1_n", M1_n, 1'b1);
        check("rst.iorq_n", IORQ_n, 1'b1);
        check("rst.rd_n", RD_n, 1'b1);
        check("rst.do_en", DO_EN, 1'b0);
        check("rst.do", DO, 8'h00);
        check("rst.busy", BUSY, 1'b0);
        check("rst.vec_valid", VEC_VALID, 1'b0);
        check("rst.reti_done", RETI_DONE, 1'b0);
        check("rst.vec_addr", VEC_ADDR, 16'h0000);
        check("rst.iei_top", IEI_TOP, 1'b1);
        RESET = 1'b0;

        clear_sc(); sc_page = 8'h12; sc_vec = 8'h35; sc_int_at = 1;
        run_scenario("ack_1234");
        check("ack_1234.addr", VEC_ADDR, 16'h1234);

        clear_sc(); sc_pre_low = 1'b1; sc_ie_at = 3;
        run_scenario("ie_gate");

        clear_sc(); sc_reti_at = 1;
        run_scenario("reti");
        check("reti.ieo_released", !periph_srv, 1'b1);

        clear_sc(); sc_pre_low = 1'b1; sc_ie_at = 2; sc_reti_at = 2;
        run_scenario("reti_int_same");

        clear_sc(); sc_int_at = 1; sc_reti_at = 5;
        run_scenario("reti_in_ack");

        clear_sc(); sc_int_at = 1; sc_rst_at = 6;
        run_scenario("rst_in_io");

        for (int it = 0; it < 14; it++) begin
            clear_sc();
            kind = $urandom_range(0, 5);
            case (kind)
                0: sc_int_at = $urandom_range(1, 3);
                1: begin sc_pre_low = 1'b1; sc_ie_at = $urandom_range(1, 6); end
                2: sc_reti_at = $urandom_range(1, 4);
                3: begin
                    sc_pre_low = 1'b1;
                    sc_ie_at   = $urandom_range(1, 4);
                    sc_reti_at = sc_ie_at;
                end
                4: begin
                    sc_int_at  = 1;
                    sc_reti_at = $urandom_range(4, TW + 5);
                    if ($urandom_range(0, 1) == 1) sc_reti2_at = $urandom_range(sc_reti_at + 1, TW + 6);
                    if ($urandom_range(0, 1) == 1) sc_ie_off = 4;
                end
                default: begin
                    sc_int_at = 1;
                    sc_rst_at = $urandom_range(6, 5 + TW);
                end
            endcase
            run_scenario($sformatf("rnd%0d_k%0d", it, kind));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
